adc083000_capture_seq: RTL and testbench

ADC083000_CAPTURE_SEQ -- requirements
Module: adc083000_capture_seq

---
 rtl/adc083000_ctrl_pkg.sv | 17 +
 rtl/sync_2ff.sv | 21 ++
 rtl/adc083000_capture_seq.sv | 112 +++++++++++
 tb/tb_adc083000_capture_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/adc083000_ctrl_pkg.sv
// adc083000_ctrl_pkg: state encodings and default timing for the ADC083000 capture sequencer.
package adc083000_ctrl_pkg;

    typedef enum logic [2:0] {
        DCM_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        FIFO_RST  = 3'd2,
        SETTLE    = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int DEF_DCM_RST_CYCLES  = 8;
    localparam int DEF_FIFO_RST_CYCLES = 16;
    localparam int DEF_SETTLE_CYCLES   = 32;
    localparam int DEF_LOCK_TIMEOUT    = 4096;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc083000_capture_seq.sv
// adc083000_capture_seq: DCM/FIFO reset and capture-enable sequencer with lock and overflow recovery.
module adc083000_capture_seq
    import adc083000_ctrl_pkg::*;
#(
    parameter int DCM_RST_CYCLES  = DEF_DCM_RST_CYCLES,
    parameter int FIFO_RST_CYCLES = DEF_FIFO_RST_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT
) (
    input  logic       ctrl_clk_in,
    input  logic       ctrl_reset,
    input  logic       adc_dcm_locked,
    input  logic       fifo0_full,
    input  logic       fifo1_full,
    input  logic       restart_req,
    output logic       dcm_reset,
    output logic       fifo_reset,
    output logic       capture_enable,
    output logic       ready,
    output logic [2:0] state,
    output logic       lock_timeout,
    output logic [7:0] lock_loss_count,
    output logic [7:0] overflow_count
);

    state_t      cur, nxt;
    logic [31:0] timer, timer_nxt;
    logic        lock_s, full0_s, full1_s;
    logic        loss_inc, ovf_inc, timeout_set;

    sync_2ff u_sync_lock  (.clk(ctrl_clk_in), .rst(ctrl_reset), .d(adc_dcm_locked), .q(lock_s));
    sync_2ff u_sync_full0 (.clk(ctrl_clk_in), .rst(ctrl_reset), .d(fifo0_full),     .q(full0_s));
    sync_2ff u_sync_full1 (.clk(ctrl_clk_in), .rst(ctrl_reset), .d(fifo1_full),     .q(full1_s));

    // Timer holds (remaining cycles - 1); a state lasting N cycles is loaded with N-1.
    function automatic logic [31:0] load_val(input state_t s);
        case (s)
            DCM_RST:   return 32'(DCM_RST_CYCLES - 1);
            WAIT_LOCK: return 32'(LOCK_TIMEOUT - 1);
            FIFO_RST:  return 32'(FIFO_RST_CYCLES - 1);
            SETTLE:    return 32'(SETTLE_CYCLES - 1);
            default:   return 32'd0;
        endcase
    endfunction

    always_comb begin
        nxt         = cur;
        loss_inc    = 1'b0;
        ovf_inc     = 1'b0;
        timeout_set = 1'b0;
        if (restart_req) begin
            nxt = DCM_RST;
        end else begin
            case (cur)
                DCM_RST:   nxt = (timer == 32'd0) ? WAIT_LOCK : DCM_RST;
                WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt = FIFO_RST;
                    end else if (timer == 32'd0) begin
                        nxt         = DCM_RST;
                        timeout_set = 1'b1;
                    end
                end
                FIFO_RST:  nxt = !lock_s ? DCM_RST : (timer == 32'd0) ? SETTLE : FIFO_RST;
                SETTLE:    nxt = !lock_s ? DCM_RST : (timer == 32'd0) ? RUN : SETTLE;
                RUN: begin
                    if (!lock_s) begin
                        nxt      = DCM_RST;
                        loss_inc = 1'b1;
                    end else if (full0_s || full1_s) begin
                        nxt     = FIFO_RST;
                        ovf_inc = 1'b1;
                    end
                end
                default:   nxt = DCM_RST;
            endcase
        end
        // Restart re-enters DCM_RST even from DCM_RST, so it always reloads.
        timer_nxt = (restart_req || nxt != cur) ? load_val(nxt) :
                    (timer == 32'd0) ? 32'd0 : timer - 32'd1;
    end

    always_ff @(posedge ctrl_clk_in) begin
        if (ctrl_reset) begin
            cur             <= DCM_RST;
            timer           <= load_val(DCM_RST);
            dcm_reset       <= 1'b1;
            fifo_reset      <= 1'b1;
            capture_enable  <= 1'b0;
            ready           <= 1'b0;
            lock_timeout    <= 1'b0;
            lock_loss_count <= 8'd0;
            overflow_count  <= 8'd0;
        end else begin
            cur            <= nxt;
            timer          <= timer_nxt;
            dcm_reset      <= nxt == DCM_RST;
            fifo_reset     <= nxt == DCM_RST || nxt == WAIT_LOCK || nxt == FIFO_RST;
            capture_enable <= nxt == RUN;
            ready          <= nxt == RUN;
            if (timeout_set)
                lock_timeout <= 1'b1;
            if (loss_inc && lock_loss_count != 8'hFF)
                lock_loss_count <= lock_loss_count + 8'd1;
            if (ovf_inc && overflow_count != 8'hFF)
                overflow_count <= overflow_count + 8'd1;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_adc083000_capture_seq.sv
// tb_adc083000_capture_seq: directed table-driven and sequence checks for the capture sequencer.
module tb_adc083000_capture_seq;

    logic       clk = 1'b0;
    logic       rst, lock, f0, f1, restart;
    logic       dcm_reset, fifo_reset, capture_enable, ready, lock_timeout;
    logic [2:0] state;
    logic [7:0] lock_loss_count, overflow_count;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        int st;
        int dur;
        bit dcm;
        bit fifo;
        bit cap;
        bit rdy;
    } phase_t;

    phase_t tbl[5];

    adc083000_capture_seq dut (
        .ctrl_clk_in(clk),
        .ctrl_reset(rst),
        .adc_dcm_locked(lock),
        .fifo0_full(f0),
        .fifo1_full(f1),
        .restart_req(restart),
        .dcm_reset(dcm_reset),
        .fifo_reset(fifo_reset),
        .capture_enable(capture_enable),
        .ready(ready),
        .state(state),
        .lock_timeout(lock_timeout),
        .lock_loss_count(lock_loss_count),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_dcm"}, int'(dcm_reset), 1);
        chk({tag, "_fifo"}, int'(fifo_reset), 1);
        chk({tag, "_cap"}, int'(capture_enable), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_tmo"}, int'(lock_timeout), 0);
        chk({tag, "_loss"}, int'(lock_loss_count), 0);
        chk({tag, "_ovf"}, int'(overflow_count), 0);
    endtask

    task automatic count_state(input int st, output int n);
        n = 0;
        while (int'(state) == st && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input int st, input int lim, input string name);
        int n = 0;
        while (int'(state) != st && n < lim) begin
            n++;
            @(negedge clk);
        end
        chk(name, int'(state), st);
    endtask

    initial begin
        int n;
        bit saw3, saw_dcm;
        tbl[0] = '{0, 8,  1, 1, 0, 0};
        tbl[1] = '{1, 15, 0, 1, 0, 0};
        tbl[2] = '{2, 16, 0, 1, 0, 0};
        tbl[3] = '{3, 32, 0, 0, 0, 0};
        tbl[4] = '{4, 0,  0, 0, 1, 1};
        rst = 1'b1; lock = 1'b0; f0 = 1'b0; f1 = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        fork
            begin
                repeat (20) @(negedge clk);
                lock = 1'b1;
            end
        join_none
        // Power-up: each table row is a state visited in order, its outputs and its length.
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pu%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("pu%0d_dcm", i), int'(dcm_reset), int'(tbl[i].dcm));
            chk($sformatf("pu%0d_fifo", i), int'(fifo_reset), int'(tbl[i].fifo));
            chk($sformatf("pu%0d_cap", i), int'(capture_enable), int'(tbl[i].cap));
            chk($sformatf("pu%0d_ready", i), int'(ready), int'(tbl[i].rdy));
            if (tbl[i].dur > 0) begin
                count_state(tbl[i].st, n);
                chk($sformatf("pu%0d_len", i), n, tbl[i].dur);
            end
        end
        // Single-cycle overflow on FIFO 1.
        repeat (5) @(negedge clk);
        f1 = 1'b1;
        @(negedge clk);
        f1 = 1'b0;
        n = 0;
        while (state == 3'd4 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("ovf_to_fifo_rst", int'(state), 2);
        chk("ovf_count1", int'(overflow_count), 1);
        chk("ovf_loss0", int'(lock_loss_count), 0);
        saw3 = 1'b0; saw_dcm = 1'b0; n = 0;
        while (state != 3'd4 && n < 100) begin
            saw3 |= (state == 3'd3);
            saw_dcm |= dcm_reset;
            n++;
            @(negedge clk);
        end
        chk("ovf_saw_settle", int'(saw3), 1);
        chk("ovf_dcm_stays_low", int'(saw_dcm), 0);
        chk("ovf_back_run", int'(state), 4);
        chk("ovf_ready", int'(ready), 1);
        // Lock loss and overflow together: only the loss counts.
        repeat (3) @(negedge clk);
        lock = 1'b0; f0 = 1'b1;
        n = 0;
        while (state == 3'd4 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("loss_state", int'(state), 0);
        chk("loss_count", int'(lock_loss_count), 1);
        chk("loss_ovf_unchanged", int'(overflow_count), 1);
        chk("loss_cap", int'(capture_enable), 0);
        f0 = 1'b0; lock = 1'b1;
        // Restart in the middle of SETTLE.
        wait_state(3, 200, "rs_reach_settle");
        repeat (5) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_state", int'(state), 0);
        chk("rs_loss", int'(lock_loss_count), 1);
        chk("rs_ovf", int'(overflow_count), 1);
        wait_state(4, 200, "rs_back_run");
        // Continuous overflow: the counter must stick at 255.
        f0 = 1'b1;
        repeat (15000) @(negedge clk);
        chk("sat_ovf", int'(overflow_count), 255);
        chk("sat_loss", int'(lock_loss_count), 1);
        f0 = 1'b0;
        wait_state(4, 200, "sat_back_run");
        chk("sat_ovf_hold", int'(overflow_count), 255);
        // Reset in RUN.
        repeat (3) @(negedge clk);
        rst = 1'b1; lock = 1'b0;
        @(negedge clk);
        check_reset("rst_run");
        rst = 1'b0;
        // Lock never comes: timeout after DCM_RST + LOCK_TIMEOUT.
        count_state(0, n);
        chk("tmo_dcm_len", n, 8);
        chk("tmo_flag_early", int'(lock_timeout), 0);
        count_state(1, n);
        chk("tmo_wait_len", n, 4096);
        chk("tmo_state", int'(state), 0);
        chk("tmo_flag", int'(lock_timeout), 1);
        lock = 1'b1;
        wait_state(4, 300, "tmo_recover_run");
        chk("tmo_sticky", int'(lock_timeout), 1);
        chk("tmo_ready", int'(ready), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("final");
        rst = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
